// File: rtl/aeses_ctrl_pkg.sv
// Shared types and constants for the AESES UART command sequencer.
package aeses_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, KEY_RX, KEY_EXP, BLK_RX, CORE_RUN, TX_OUT
  } state_e;

  // Control byte fields: [7]=K, [6:5]=mode, [4]=GO, [3]=ENC, [2:0] reserved
  localparam int CB_K       = 7;
  localparam int CB_MODE_HI = 6;
  localparam int CB_MODE_LO = 5;
  localparam int CB_GO      = 4;
  localparam int CB_ENC     = 3;

  localparam int KEY_BYTES = 32;
  localparam int BLK_BYTES = 16;

  localparam logic [1:0] MODE_128 = 2'd0;
  localparam logic [1:0] MODE_192 = 2'd1;
  localparam logic [1:0] MODE_256 = 2'd2;

  function automatic logic mode_ok(input logic [1:0] m);
    return (m == MODE_128) || (m == MODE_192) || (m == MODE_256);
  endfunction

  // Number of significant key bytes; a reserved mode keeps all 32 (it never reaches the core).
  function automatic logic [5:0] key_len(input logic [1:0] m);
    case (m)
      MODE_128: return 6'd16;
      MODE_192: return 6'd24;
      default:  return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/aeses_byte_shreg.sv
// Byte-wide shift register, MSB-first shift-in, with clear and parallel load.
// OUT_BYTES selects how many top bytes are exposed on q.
module aeses_byte_shreg #(
  parameter int N_BYTES   = 16,
  parameter int OUT_BYTES = N_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   load,
  input  logic                   shift,
  input  logic [7:0]             din,
  input  logic [N_BYTES*8-1:0]   ld_data,
  output logic [OUT_BYTES*8-1:0] q
);

  localparam int W = N_BYTES * 8;

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)        q_d = '0;
    else if (load)  q_d = ld_data;
    else if (shift) q_d = {q_q[W-9:0], din};
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q[W-1 -: OUT_BYTES*8];

endmodule

// File: rtl/aeses_uart_cmd_ctrl.sv
// Command sequencer between the UART byte link and the AESES core.
// Optional inter-byte RX timeout enabled by defining AESES_CTRL_TIMEOUT_EN.
module aeses_uart_cmd_ctrl
  import aeses_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [255:0] core_key,
  output logic [1:0]   core_mode,
  output logic         core_key_go,
  input  logic         core_key_rdy,
  output logic [127:0] core_blk,
  output logic         core_enc,
  output logic         core_go,
  input  logic         core_done,
  input  logic [127:0] core_res,
  output logic         busy,
  output logic         err
);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] key_mode_q, key_mode_d, op_mode_q, op_mode_d;
  logic       enc_q, enc_d, key_valid_q, key_valid_d, err_q, err_d;
  logic       key_go_q, key_go_d, go_q, go_d;

  logic         key_clr, key_shift, blk_clr, blk_shift, res_load, res_shift;
  logic [7:0]   key_din;
  logic [127:0] res_ld;
  logic         tmo_hit;

  // Bytes past the key length are shifted in as zero so the unused LSBs read 0.
  assign key_din = ({1'b0, cnt_q} < key_len(key_mode_q)) ? rx_data : 8'h00;

  aeses_byte_shreg #(.N_BYTES(KEY_BYTES)) u_key (
    .clk, .rst, .clr(key_clr), .load(1'b0), .shift(key_shift),
    .din(key_din), .ld_data('0), .q(core_key));

  aeses_byte_shreg #(.N_BYTES(BLK_BYTES)) u_blk (
    .clk, .rst, .clr(blk_clr), .load(1'b0), .shift(blk_shift),
    .din(rx_data), .ld_data('0), .q(core_blk));

  aeses_byte_shreg #(.N_BYTES(BLK_BYTES), .OUT_BYTES(1)) u_res (
    .clk, .rst, .clr(1'b0), .load(res_load), .shift(res_shift),
    .din(8'h00), .ld_data(res_ld), .q(tx_data));

`ifdef AESES_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             in_rx;

  assign in_rx   = (state_q == KEY_RX) || (state_q == BLK_RX);
  assign tmo_hit = in_rx && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = '0;
    if (in_rx && !rx_valid && !tmo_hit) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_mode_d  = key_mode_q;
    op_mode_d   = op_mode_q;
    enc_d       = enc_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;
    key_go_d    = 1'b0;
    go_d        = 1'b0;
    key_clr     = 1'b0;
    key_shift   = 1'b0;
    blk_clr     = 1'b0;
    blk_shift   = 1'b0;
    res_load    = 1'b0;
    res_shift   = 1'b0;
    res_ld      = core_res;

    case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_data[CB_K]) begin
          key_mode_d  = rx_data[CB_MODE_HI:CB_MODE_LO];
          key_valid_d = 1'b0;
          key_clr     = 1'b1;
          cnt_d       = '0;
          state_d     = KEY_RX;
          if (!mode_ok(rx_data[CB_MODE_HI:CB_MODE_LO])) err_d = 1'b1;
        end else if (rx_data[CB_GO]) begin
          op_mode_d = rx_data[CB_MODE_HI:CB_MODE_LO];
          enc_d     = rx_data[CB_ENC];
          blk_clr   = 1'b1;
          cnt_d     = '0;
          state_d   = BLK_RX;
          if (!mode_ok(rx_data[CB_MODE_HI:CB_MODE_LO])) err_d = 1'b1;
        end
      end
      KEY_RX: if (rx_valid) begin
        key_shift = 1'b1;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'(KEY_BYTES - 1)) begin
          cnt_d = '0;
          if (mode_ok(key_mode_q)) begin
            key_go_d = 1'b1;
            state_d  = KEY_EXP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      KEY_EXP: begin
        if (rx_valid) err_d = 1'b1;
        // core_key_rdy may still be high from a previous key during the go cycle.
        if (!key_go_q && core_key_rdy) begin
          key_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      BLK_RX: if (rx_valid) begin
        blk_shift = 1'b1;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'(BLK_BYTES - 1)) begin
          cnt_d = '0;
          if (key_valid_q && (op_mode_q == key_mode_q)) begin
            go_d    = 1'b1;
            state_d = CORE_RUN;
          end else begin
            err_d    = 1'b1;
            res_load = 1'b1;
            res_ld   = '0;
            state_d  = TX_OUT;
          end
        end
      end
      CORE_RUN: begin
        if (rx_valid) err_d = 1'b1;
        if (core_done) begin
          res_load = 1'b1;
          state_d  = TX_OUT;
        end
      end
      TX_OUT: begin
        if (rx_valid) err_d = 1'b1;
        if (tx_ready) begin
          res_shift = 1'b1;
          cnt_d     = cnt_q + 5'd1;
          if (cnt_q == 5'(BLK_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (tmo_hit) begin
      err_d   = 1'b1;
      cnt_d   = '0;
      state_d = IDLE;
      key_clr = (state_q == KEY_RX);
      blk_clr = (state_q == BLK_RX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_mode_q  <= '0;
      op_mode_q   <= '0;
      enc_q       <= 1'b0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      key_go_q    <= 1'b0;
      go_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_mode_q  <= key_mode_d;
      op_mode_q   <= op_mode_d;
      enc_q       <= enc_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      key_go_q    <= key_go_d;
      go_q        <= go_d;
    end
  end

  assign tx_valid    = (state_q == TX_OUT);
  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign core_key_go = key_go_q;
  assign core_go     = go_q;
  assign core_enc    = enc_q;
  assign core_mode   = key_mode_q;

endmodule

// File: tb/tb_aeses_uart_cmd_ctrl.sv
// Scoreboard bench for aeses_uart_cmd_ctrl with a behavioural AESES core model.
module tb_aeses_uart_cmd_ctrl;
  import aeses_ctrl_pkg::*;

  logic         clk, rst;
  logic [7:0]   rx_data, tx_data;
  logic         rx_valid, tx_valid, tx_ready;
  logic [255:0] core_key;
  logic [1:0]   core_mode;
  logic         core_key_go, core_key_rdy, core_enc, core_go, core_done, busy, err;
  logic [127:0] core_blk, core_res;

  aeses_uart_cmd_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .core_key(core_key), .core_mode(core_mode), .core_key_go(core_key_go),
    .core_key_rdy(core_key_rdy), .core_blk(core_blk), .core_enc(core_enc),
    .core_go(core_go), .core_done(core_done), .core_res(core_res),
    .busy(busy), .err(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] KIN192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_eeeeeeeeeeeeeeee;
  localparam logic [255:0] EXP192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
  localparam logic [255:0] KIN128 = 256'h2b7e151628aed2a6abf7158809cf4f3c_77777777777777777777777777777777;
  localparam logic [255:0] EXP128 = 256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT     = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] PT2    = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_q[$];

  // Core model state (written only by the model process)
  int key_go_cnt = 0, go_cnt = 0, key_cd = 0, blk_cd = 0;
  logic [255:0] key_at_go;
  logic [1:0]   mode_at_go;
  logic         enc_at_go;
  logic [127:0] res_pend;

  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic [127:0] b, input logic e);
    if (k == EXP192 && b == PT && e) return CT;
    return b ^ k[255:128] ^ (e ? {16{8'h5a}} : {16{8'ha5}});
  endfunction

  initial begin
    core_key_rdy = 1'b0; core_done = 1'b0; core_res = '0;
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      if (core_key_go) begin
        key_go_cnt++; key_at_go = core_key; mode_at_go = core_mode;
        core_key_rdy = 1'b0; key_cd = 5;
      end else if (key_cd > 0) begin
        key_cd--;
        if (key_cd == 0) core_key_rdy = 1'b1;
      end
      if (core_go) begin
        go_cnt++; enc_at_go = core_enc;
        res_pend = core_fn(core_key, core_blk, core_enc); blk_cd = 8;
      end else if (blk_cd > 0) begin
        blk_cd--;
        if (blk_cd == 0) begin core_done = 1'b1; core_res = res_pend; end
      end
    end
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic apply_reset;
    rst = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick;
    rx_valid = 1'b0;
  endtask

  task automatic send_key(input logic [1:0] m, input logic [255:0] k);
    send_byte({1'b1, m, 5'd0});
    for (int i = 0; i < 32; i++) send_byte(k[255-8*i -: 8]);
  endtask

  task automatic send_blk(input logic [1:0] m, input logic e, input logic [127:0] b);
    send_byte({1'b0, m, 1'b1, e, 3'd0});
    for (int i = 0; i < 16; i++) send_byte(b[127-8*i -: 8]);
  endtask

  task automatic push_exp(input logic [127:0] r);
    for (int i = 0; i < 16; i++) exp_q.push_back(r[127-8*i -: 8]);
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (busy && cyc < 500) begin tick; cyc++; end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s idle timeout: busy=%b want 0", name, busy); end
  endtask

  // Drains the 16-byte reply with random tx_ready stalls, popping the scoreboard per handshake.
  task automatic collect(input string name);
    int got = 0, cyc = 0;
    logic [7:0] e;
    while (got < 16 && cyc < 3000) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if (tx_valid && tx_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_tests++;
        if (tx_data !== e) begin n_fail++; $display("FAIL %s byte%0d: got %h want %h", name, got, tx_data, e); end
        got++;
      end
      tick; cyc++;
    end
    tx_ready = 1'b0;
    n_tests++;
    if (got != 16 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s reply end: bytes=%0d tx_valid=%b busy=%b want 16/0/0", name, got, tx_valid, busy);
    end
    exp_q.delete();
  endtask

  task automatic check_err(input string name, input logic want);
    n_tests++;
    if (err !== want) begin n_fail++; $display("FAIL %s err: got %b want %b", name, err, want); end
  endtask

  task automatic check_go(input string name, input int g0, input int want);
    n_tests++;
    if (go_cnt - g0 != want) begin n_fail++; $display("FAIL %s core_go count: got %0d want %0d", name, go_cnt - g0, want); end
  endtask

  task automatic test_reset;
    apply_reset;
    n_tests++;
    if ({busy, err, tx_valid, core_key_go, core_go, core_enc, core_mode, tx_data} !== '0 ||
        core_key !== '0 || core_blk !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: busy=%b err=%b txv=%b kgo=%b go=%b key=%h blk=%h want all 0",
               busy, err, tx_valid, core_key_go, core_go, core_key, core_blk);
    end
  endtask

  task automatic test_key_load;
    int k0 = key_go_cnt;
    send_key(MODE_192, KIN192);
    wait_idle("key192");
    n_tests++;
    if (key_go_cnt - k0 != 1) begin n_fail++; $display("FAIL key192 key_go count: got %0d want 1", key_go_cnt - k0); end
    n_tests++;
    if (key_at_go !== EXP192 || mode_at_go !== MODE_192) begin
      n_fail++; $display("FAIL key192 key/mode: got %h/%0d want %h/%0d", key_at_go, mode_at_go, EXP192, MODE_192);
    end
    check_err("key192", 1'b0);
  endtask

  task automatic test_block_enc(input string name);
    int g0 = go_cnt;
    push_exp(CT);
    send_blk(MODE_192, 1'b1, PT);
    collect(name);
    check_go(name, g0, 1);
    n_tests++;
    if (enc_at_go !== 1'b1) begin n_fail++; $display("FAIL %s core_enc: got %b want 1", name, enc_at_go); end
    check_err(name, 1'b0);
  endtask

  task automatic test_back_to_back;
    int g0;
    for (int i = 0; i < 3; i++) test_block_enc($sformatf("repeat%0d", i));
    g0 = go_cnt;
    push_exp(core_fn(EXP192, PT2, 1'b0));
    send_blk(MODE_192, 1'b0, PT2);
    collect("decrypt");
    check_go("decrypt", g0, 1);
    check_err("decrypt", 1'b0);
  endtask

  task automatic test_overrun;
    push_exp(CT);
    send_blk(MODE_192, 1'b1, PT);
    send_byte(8'h55);
    check_err("overrun", 1'b1);
    collect("overrun");
  endtask

  task automatic test_mode_mismatch;
    int g0;
    apply_reset;
    send_key(MODE_128, KIN128);
    wait_idle("key128");
    g0 = go_cnt;
    push_exp('0);
    send_blk(MODE_256, 1'b1, PT);
    collect("mismatch");
    check_go("mismatch", g0, 0);
    check_err("mismatch", 1'b1);
  endtask

  task automatic test_reserved_mode;
    int k0, g0;
    apply_reset;
    k0 = key_go_cnt;
    send_key(2'b11, KIN128);
    tick;
    n_tests++;
    if (key_go_cnt != k0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reserved key: key_go=%0d busy=%b want 0/0", key_go_cnt - k0, busy);
    end
    check_err("reserved key", 1'b1);
    g0 = go_cnt;
    push_exp('0);
    send_blk(2'b11, 1'b1, PT);
    collect("reserved blk");
    check_go("reserved blk", g0, 0);
  endtask

  task automatic test_reset_key;
    int g0;
    apply_reset;
    send_key(MODE_128, KIN128);
    wait_idle("key128b");
    g0 = go_cnt;
    push_exp(core_fn(EXP128, PT, 1'b1));
    send_blk(MODE_128, 1'b1, PT);
    collect("blk128");
    check_go("blk128", g0, 1);
    check_err("blk128", 1'b0);
    // Reset after a valid key: key must be forgotten
    apply_reset;
    g0 = go_cnt;
    push_exp('0);
    send_blk(MODE_128, 1'b1, PT);
    collect("post-reset blk");
    check_go("post-reset blk", g0, 0);
    check_err("post-reset blk", 1'b1);
    // Reset in the middle of a key download
    apply_reset;
    send_byte({1'b1, MODE_128, 5'd0});
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid-key busy: got %b want 1", busy); end
    rst = 1'b0; tick; rst = 1'b1; tick;
    n_tests++;
    if (busy !== 1'b0 || core_key !== '0) begin
      n_fail++; $display("FAIL mid-key reset: busy=%b key=%h want 0/0", busy, core_key);
    end
    check_err("mid-key reset", 1'b0);
  endtask

`ifdef AESES_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    int n = 0;
    apply_reset;
    send_byte({1'b1, MODE_128, 5'd0});
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    while (busy && n < 400) begin tick; n++; end
    n_tests++;
    if (n != 100) begin n_fail++; $display("FAIL timeout cycles: got %0d want 100", n); end
    check_err("timeout", 1'b1);
    push_exp('0);
    send_blk(MODE_128, 1'b1, PT);
    collect("timeout blk");
  endtask
`endif

  initial begin
    rst = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    test_reset;
    test_key_load;
    test_block_enc("enc192");
    test_back_to_back;
    test_overrun;
    test_mode_mismatch;
    test_reserved_mode;
    test_reset_key;
`ifdef AESES_CTRL_TIMEOUT_EN
    test_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
